// File: rtl/led_pkg.sv
// Shared constants for the blink generator and the LED fader that consumes its output.
package led_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_UP   = 2'd1,
      ST_ON   = 2'd2,
      ST_DOWN = 2'd3
   } fader_state_t;

   localparam int DEF_PWM_BITS = 8;
   localparam int DEF_STEP_DIV = 4096;

   // Blink generator widths, kept here so both blocks agree on them.
   localparam int BLINK_CNT_BITS = 24;
   localparam int BLINK_LED_BITS = 1;

endpackage

// File: rtl/led_fader_if.sv
// Bundles the LED request and the fader's drive/status outputs.
interface led_fader_if
   import led_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
);
   logic                in_led;
   logic                out_pwm;
   logic [PWM_BITS-1:0] out_level;
   logic                out_busy;

   modport master (
      output in_led,
      input  out_pwm,
      input  out_level,
      input  out_busy
   );

   modport slave (
      input  in_led,
      output out_pwm,
      output out_level,
      output out_busy
   );
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a registered compare against the brightness level.
module led_pwm_gen
   import led_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PWM_BITS-1:0] in_level,
   output logic                out_pwm
);

   localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
   localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] r_pwmCnt;
   logic                r_pwm;

   // Full level forces the output solid high rather than one low slot per period.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pwmCnt <= '0;
         r_pwm    <= 1'b0;
      end else begin
         r_pwmCnt <= r_pwmCnt + CNT_ONE;
         r_pwm    <= (in_level == LVL_MAX) ? 1'b1 : (r_pwmCnt < in_level);
      end
   end

   assign out_pwm = r_pwm;

endmodule

// File: rtl/led_fader.sv
// Ramps an LED brightness level toward the requested on/off state and drives it as PWM.
module led_fader
   import led_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int STEP_DIV = DEF_STEP_DIV
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_led,
   output logic                out_pwm,
   output logic [PWM_BITS-1:0] out_level,
   output logic                out_busy
);

   localparam int                  PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
   localparam logic [PS_W-1:0]     PS_ONE  = PS_W'(1);
   localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
   localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

   logic                r_tgt;
   logic [PS_W-1:0]     r_prescaler;
   logic                w_tick;
   fader_state_t        r_state;
   fader_state_t        w_nextState;
   logic [PWM_BITS-1:0] r_level;
   logic [PWM_BITS-1:0] w_nextLevel;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tgt <= 1'b0;
      end else begin
         r_tgt <= in_led;
      end
   end

   // Prescaler free-runs; target changes do not realign the step phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prescaler <= '0;
      end else if (w_tick) begin
         r_prescaler <= '0;
      end else begin
         r_prescaler <= r_prescaler + PS_ONE;
      end
   end

   assign w_tick = (r_prescaler == PS_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_OFF;
         r_level <= '0;
      end else begin
         r_state <= w_nextState;
         r_level <= w_nextLevel;
      end
   end

   // A direction change always wins over a coincident tick, freezing the level for that cycle.
   always_comb begin
      w_nextState = r_state;
      w_nextLevel = r_level;
      case (r_state)
         ST_OFF: begin
            if (r_tgt) begin
               w_nextState = ST_UP;
            end
         end
         ST_UP: begin
            if (!r_tgt) begin
               w_nextState = ST_DOWN;
            end else if (w_tick) begin
               if (r_level != LVL_MAX) begin
                  w_nextLevel = r_level + LVL_ONE;
                  if ((r_level + LVL_ONE) == LVL_MAX) begin
                     w_nextState = ST_ON;
                  end
               end else begin
                  w_nextState = ST_ON;
               end
            end
         end
         ST_ON: begin
            if (!r_tgt) begin
               w_nextState = ST_DOWN;
            end
         end
         ST_DOWN: begin
            if (r_tgt) begin
               w_nextState = ST_UP;
            end else if (w_tick) begin
               if (r_level != '0) begin
                  w_nextLevel = r_level - LVL_ONE;
                  if (r_level == LVL_ONE) begin
                     w_nextState = ST_OFF;
                  end
               end else begin
                  w_nextState = ST_OFF;
               end
            end
         end
         default: begin
            w_nextState = ST_OFF;
         end
      endcase
   end

   assign out_busy  = (r_state == ST_UP) | (r_state == ST_DOWN);
   assign out_level = r_level;

   led_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwmGen (
      .clock    (clock),
      .reset    (reset),
      .in_level (r_level),
      .out_pwm  (out_pwm)
   );

endmodule
